circle_sweep: RTL and testbench

//  Upstream sequencer for the 1024-step circle point generator: steps a 10-bit angle by a

---
 rtl/circle_sweep.sv | 168 ++++++++++++++++
 tb/tb_circle_sweep.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/circle_sweep.sv
// Sequencer for the circle point generator. It steps the angle, runs one req/ack per point,
// and emits each point on a valid/ready stream. Optional ack timeout: CIRCLE_SWEEP_TIMEOUT_EN.
module circle_sweep #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [9:0]  angle0_i,
  input  logic [9:0]  step_i,
  input  logic [10:0] count_i,
  input  logic [7:0]  r_i,
  input  logic [7:0]  x0_i,
  input  logic [7:0]  y0_i,
  output logic [9:0]  c_angle_o,
  output logic [7:0]  c_r_o,
  output logic [7:0]  c_x0_o,
  output logic [7:0]  c_y0_o,
  output logic        c_req_o,
  input  logic        c_ack_i,
  input  logic [7:0]  c_x_i,
  input  logic [7:0]  c_y_i,
  output logic [7:0]  pt_x_o,
  output logic [7:0]  pt_y_o,
  output logic        pt_valid_o,
  input  logic        pt_ready_i,
  output logic        pt_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [9:0]  step;
  logic [10:0] count;
  logic [10:0] remaining;
  logic        stop_pend;
  logic        timeout;

`ifdef CIRCLE_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Counts cycles spent in S_WAIT; held at zero elsewhere so each wait starts fresh.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timeout = (state == S_WAIT) && !c_ack_i && (wait_cnt == TW'(ACK_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_i) next_state = S_REQ;
        else         next_state = S_IDLE;
      end
      S_REQ: next_state = S_WAIT;
      S_WAIT: begin
        if (c_ack_i)      next_state = S_OUT;
        else if (timeout) next_state = S_IDLE;
        else              next_state = S_WAIT;
      end
      S_OUT: begin
        if (pt_valid_o && pt_ready_i) begin
          if (pt_last_o || stop_pend) next_state = S_IDLE;
          else                        next_state = S_REQ;
        end else begin
          next_state = S_OUT;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; req/busy are derived from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_angle_o  <= 10'd0;
      c_r_o      <= 8'd0;
      c_x0_o     <= 8'd0;
      c_y0_o     <= 8'd0;
      c_req_o    <= 1'b0;
      pt_x_o     <= 8'd0;
      pt_y_o     <= 8'd0;
      pt_valid_o <= 1'b0;
      pt_last_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      step       <= 10'd0;
      count      <= 11'd0;
      remaining  <= 11'd0;
      stop_pend  <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      c_req_o <= (next_state == S_REQ);
      busy_o  <= (next_state != S_IDLE);
      if ((state != S_IDLE) && stop_i) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            c_angle_o <= angle0_i;
            step      <= step_i;
            count     <= count_i;
            remaining <= count_i;
            c_r_o     <= r_i;
            c_x0_o    <= x0_i;
            c_y0_o    <= y0_i;
            stop_pend <= 1'b0;
            err_o     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (c_ack_i) begin
            pt_x_o     <= c_x_i;
            pt_y_o     <= c_y_i;
            pt_valid_o <= 1'b1;
            pt_last_o  <= (count != 11'd0) && (remaining == 11'd1);
            c_angle_o  <= c_angle_o + step;
            if (count != 11'd0) remaining <= remaining - 11'd1;
          end else if (timeout) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
          end
        end
        S_OUT: begin
          if (pt_valid_o && pt_ready_i) begin
            pt_valid_o <= 1'b0;
            pt_last_o  <= 1'b0;
            if (pt_last_o || stop_pend) done_o <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_sweep.sv
// Directed self-checking bench for circle_sweep; the circle responder returns x = angle/4, y = ~x.
module tb_circle_sweep;
  logic        clock = 1'b0;
  logic        reset, start_i, stop_i, c_ack_i, pt_ready_i;
  logic [9:0]  angle0_i, step_i;
  logic [10:0] count_i;
  logic [7:0]  r_i, x0_i, y0_i, c_x_i, c_y_i;
  logic [9:0]  c_angle_o;
  logic [7:0]  c_r_o, c_x0_o, c_y0_o, pt_x_o, pt_y_o;
  logic        c_req_o, pt_valid_o, pt_last_o, busy_o, done_o, err_o;
  int tests = 0;
  int fails = 0;

  circle_sweep dut (
    .clock(clock), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .angle0_i(angle0_i), .step_i(step_i), .count_i(count_i),
    .r_i(r_i), .x0_i(x0_i), .y0_i(y0_i),
    .c_angle_o(c_angle_o), .c_r_o(c_r_o), .c_x0_o(c_x0_o), .c_y0_o(c_y0_o),
    .c_req_o(c_req_o), .c_ack_i(c_ack_i), .c_x_i(c_x_i), .c_y_i(c_y_i),
    .pt_x_o(pt_x_o), .pt_y_o(pt_y_o), .pt_valid_o(pt_valid_o), .pt_ready_i(pt_ready_i),
    .pt_last_o(pt_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [9:0] a0, input logic [9:0] st, input logic [10:0] cnt);
    angle0_i = a0; step_i = st; count_i = cnt;
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic do_point(input logic [9:0] exp_angle, input logic [7:0] exp_x, input logic [7:0] exp_y,
                          input logic exp_last, input int ready_delay, input logic stop_now);
    for (int i = 0; i < 20 && c_req_o !== 1'b1; i++) @(negedge clock);
    check("req_seen", c_req_o, 1);
    check("angle", c_angle_o, exp_angle);
    @(negedge clock);
    check("req_pulse", c_req_o, 0);
    c_ack_i = 1'b1;
    c_x_i = c_angle_o[9:2];
    c_y_i = ~c_angle_o[9:2];
    stop_i = stop_now;
    @(negedge clock);
    c_ack_i = 1'b0; stop_i = 1'b0; c_x_i = 8'd0; c_y_i = 8'd0;
    check("pt_valid", pt_valid_o, 1);
    check("pt_x", pt_x_o, exp_x);
    check("pt_y", pt_y_o, exp_y);
    check("pt_last", pt_last_o, exp_last);
    if (ready_delay > 0) begin
      pt_ready_i = 1'b0;
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clock);
        check("hold_valid", pt_valid_o, 1);
        check("hold_x", pt_x_o, exp_x);
        check("hold_noreq", c_req_o, 0);
      end
      pt_ready_i = 1'b1;
    end
    @(negedge clock);
    check("pt_taken", pt_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_req;
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; c_ack_i = 1'b0; pt_ready_i = 1'b1;
    angle0_i = 10'd0; step_i = 10'd0; count_i = 11'd0;
    r_i = 8'd100; x0_i = 8'd128; y0_i = 8'd128; c_x_i = 8'd0; c_y_i = 8'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy_o, 0);
    check("rst_req", c_req_o, 0);
    check("rst_valid", pt_valid_o, 0);
    check("rst_angle", c_angle_o, 0);
    check("rst_r", c_r_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    reset = 1'b0;
    @(negedge clock);

    // Four-point finite sweep
    start_sweep(10'd0, 10'd256, 11'd4);
    check("busy", busy_o, 1);
    check("c_r", c_r_o, 100);
    check("c_x0", c_x0_o, 128);
    check("c_y0", c_y0_o, 128);
    do_point(10'd0,   8'd0,   8'd255, 1'b0, 0, 1'b0);
    do_point(10'd256, 8'd64,  8'd191, 1'b0, 0, 1'b0);
    do_point(10'd512, 8'd128, 8'd127, 1'b0, 0, 1'b0);
    do_point(10'd768, 8'd192, 8'd63,  1'b1, 0, 1'b0);
    check("t1_done", done_o, 1);
    check("t1_busy", busy_o, 0);
    @(negedge clock);
    check("t1_done_pulse", done_o, 0);

    // Backpressure on point 2
    start_sweep(10'd0, 10'd256, 11'd4);
    do_point(10'd0,   8'd0,   8'd255, 1'b0, 0,  1'b0);
    do_point(10'd256, 8'd64,  8'd191, 1'b0, 10, 1'b0);
    do_point(10'd512, 8'd128, 8'd127, 1'b0, 0,  1'b0);
    do_point(10'd768, 8'd192, 8'd63,  1'b1, 0,  1'b0);
    check("t2_done", done_o, 1);

    // Angle wrap
    @(negedge clock);
    start_sweep(10'd1020, 10'd8, 11'd2);
    do_point(10'd1020, 8'd255, 8'd0,   1'b0, 0, 1'b0);
    do_point(10'd4,    8'd1,   8'd254, 1'b1, 0, 1'b0);
    check("t3_done", done_o, 1);

    // Continuous sweep stopped during the third wait
    @(negedge clock);
    start_sweep(10'd100, 10'd3, 11'd0);
    do_point(10'd100, 8'd25, 8'd230, 1'b0, 0, 1'b0);
    do_point(10'd103, 8'd25, 8'd230, 1'b0, 0, 1'b0);
    do_point(10'd106, 8'd26, 8'd229, 1'b0, 0, 1'b1);
    check("t4_done", done_o, 1);
    check("t4_busy", busy_o, 0);
    saw_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (c_req_o === 1'b1) saw_req = 1'b1;
    end
    check("t4_no_req", saw_req, 0);

    // Reset during wait, then a late ack
    start_sweep(10'd300, 10'd1, 11'd3);
    check("t5_req", c_req_o, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_angle", c_angle_o, 0);
    check("t5_rst_valid", pt_valid_o, 0);
    reset = 1'b0;
    c_ack_i = 1'b1; c_x_i = 8'hAA; c_y_i = 8'h55;
    @(negedge clock);
    c_ack_i = 1'b0; c_x_i = 8'd0; c_y_i = 8'd0;
    check("t5_late_valid", pt_valid_o, 0);
    check("t5_late_x", pt_x_o, 0);
    check("t5_late_busy", busy_o, 0);
    start_sweep(10'd40, 10'd7, 11'd1);
    do_point(10'd40, 8'd10, 8'd245, 1'b1, 0, 1'b0);
    check("t5_done", done_o, 1);

    // Ack never arrives
    @(negedge clock);
    start_sweep(10'd0, 10'd1, 11'd1);
    check("t6_req", c_req_o, 1);
`ifdef CIRCLE_SWEEP_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      check("t6_no_done_yet", done_o, 0);
    end
    @(negedge clock);
    check("t6_done", done_o, 1);
    check("t6_err", err_o, 1);
    check("t6_busy", busy_o, 0);
    check("t6_no_point", pt_valid_o, 0);
    @(negedge clock);
    check("t6_err_sticky", err_o, 1);
    start_sweep(10'd0, 10'd1, 11'd1);
    check("t6_err_clear", err_o, 0);
`else
    repeat (25) @(negedge clock);
    check("t6_still_busy", busy_o, 1);
    check("t6_err_zero", err_o, 0);
    check("t6_no_done", done_o, 0);
`endif
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("final_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
